hazard_stall_unit: RTL

//  Hazard detection and pipeline stall/flush control for the 5-stage MIPS pipeline.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/hazard_stall_unit_if.sv | 55 +++++
 rtl/mdu_busy_timer.sv | 66 ++++++
 rtl/hazard_stall_unit.sv | 104 ++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared types and constants for the pipeline hazard logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } hazard_state_t;

    localparam int REG_ZERO            = 0;
    localparam int MDU_LATENCY_DEFAULT = 4;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/hazard_stall_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit_if
//  Description : ID-stage hazard inputs and PC/IF_ID/ID_EX control outputs.
//                Statistics signals exist only with HAZARD_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_stall_unit_if #(
    parameter int REG_ADDR_W = 5
`ifdef HAZARD_STATS_EN
    ,
    parameter int CNT_W = 32
`endif
);
    logic [REG_ADDR_W-1:0] if_id_rs;
    logic [REG_ADDR_W-1:0] if_id_rt;
    logic                  if_id_uses_rt;
    logic                  if_id_reads_hilo;
    logic                  if_id_is_mdu;
    logic [REG_ADDR_W-1:0] id_ex_rt;
    logic                  id_ex_mem_read;
    logic                  ex_branch_taken;

    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_bubble;
    logic                  mdu_busy;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_events;
`endif

    modport master (
        output if_id_rs, if_id_rt, if_id_uses_rt, if_id_reads_hilo, if_id_is_mdu,
        output id_ex_rt, id_ex_mem_read, ex_branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, mdu_busy
`ifdef HAZARD_STATS_EN
        ,
        input  stall_cycles, flush_events
`endif
    );

    modport slave (
        input  if_id_rs, if_id_rt, if_id_uses_rt, if_id_reads_hilo, if_id_is_mdu,
        input  id_ex_rt, id_ex_mem_read, ex_branch_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, mdu_busy
`ifdef HAZARD_STATS_EN
        ,
        output stall_cycles, flush_events
`endif
    );

endinterface : hazard_stall_unit_if
`default_nettype wire

// File: rtl/mdu_busy_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_busy_timer
//  Description : Tracks the multi-cycle MDU occupancy after a mult/div issues.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_busy_timer
    import pipeline_pkg::*;
#(
    parameter int MDU_LATENCY = MDU_LATENCY_DEFAULT
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic issue,
    output logic      mdu_busy
);

    localparam int TMR_W = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;
    localparam logic [TMR_W-1:0] C_LOAD = TMR_W'(MDU_LATENCY - 1);
    localparam logic [TMR_W-1:0] C_ONE  = TMR_W'(1);

    hazard_state_t    r_state;
    hazard_state_t    w_state_next;
    logic [TMR_W-1:0] r_cnt;
    logic [TMR_W-1:0] w_cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The last busy cycle is the one where the counter reads 1.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            RUN: begin
                if (issue) begin
                    w_state_next = MDU_BUSY;
                    w_cnt_next   = C_LOAD;
                end
            end
            MDU_BUSY: begin
                if (r_cnt == C_ONE) begin
                    w_state_next = RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt - C_ONE;
                end
            end
            default: begin
                w_state_next = RUN;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign mdu_busy = (r_state == MDU_BUSY);

endmodule : mdu_busy_timer
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit
//  Description : Load-use / MDU-busy stall and taken-branch flush control.
//                Optional HAZARD_STATS_EN adds stall/flush statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_LATENCY = MDU_LATENCY_DEFAULT
`ifdef HAZARD_STATS_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hazard_stall_unit_if.slave bus
);

    localparam logic [REG_ADDR_W-1:0] C_REG_ZERO = REG_ADDR_W'(REG_ZERO);

    logic w_lu;
    logic w_mdh;
    logic w_stall;
    logic w_issue;
    logic w_mdu_busy;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_if_id_flush;
    logic w_id_ex_bubble;

    assign w_lu = bus.id_ex_mem_read
                & (bus.id_ex_rt != C_REG_ZERO)
                & ((bus.id_ex_rt == bus.if_id_rs)
                   | (bus.if_id_uses_rt & (bus.id_ex_rt == bus.if_id_rt)));

    assign w_mdh   = w_mdu_busy & (bus.if_id_reads_hilo | bus.if_id_is_mdu);
    assign w_stall = w_lu | w_mdh;

    // A squashed or stalled mult/div never reaches EX, so it must not start the timer.
    assign w_issue = bus.if_id_is_mdu & ~w_stall & ~bus.ex_branch_taken & ~rst;

    mdu_busy_timer #(
        .MDU_LATENCY (MDU_LATENCY)
    ) u_mdu_busy_timer (
        .clk      (clk),
        .rst      (rst),
        .issue    (w_issue),
        .mdu_busy (w_mdu_busy)
    );

    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        if (rst) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
        end else if (bus.ex_branch_taken) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
        end else if (w_stall) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_bubble = 1'b1;
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.if_id_write  = w_if_id_write;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_bubble = w_id_ex_bubble;
    assign bus.mdu_busy     = w_mdu_busy;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!w_pc_write) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (bus.ex_branch_taken) begin
                r_flush_events <= r_flush_events + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_events = r_flush_events;
`endif

endmodule : hazard_stall_unit
`default_nettype wire
